pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage in-order core.
- Drives the global enable, per-register stall and flush inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC write enable.
- Handles run/halt sequencing, load-use interlock, taken-branch flush and data-memory wait freeze.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage in-order core: run/halt FSM, load-use
// interlock, branch flush, data-memory freeze and saturating perf counters.
module pipe_ctrl #(
  parameter int RA_W         = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pipe_en,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_we,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  drain_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic           load_use;
  logic           stall_inc, flush_inc;

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register and drain counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN && state_d == ST_DRAIN)
        drain_cnt_q <= DW'(DRAIN_CYCLES);
      else if (state_q == ST_DRAIN && !mem_busy)
        drain_cnt_q <= drain_cnt_q - DW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch
    // is inferred when a case arm leaves the signal untouched.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (halt_req && !mem_busy) state_d = ST_DRAIN;
      ST_DRAIN:  if (!mem_busy && drain_cnt_q == DW'(1)) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: same-cycle pipeline controls and counter events.
  always_comb begin
    pipe_en      = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    pc_we        = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        pipe_en = 1'b1;
        if (mem_busy) begin
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
          stall_mem_wb = 1'b1;
          stall_inc    = 1'b1;
        end else if (halt_req) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (ex_br_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          pc_we       = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
          stall_inc   = 1'b1;
        end else begin
          pc_we = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Front end is already empty; only the back half can be waiting.
        pipe_en      = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        stall_ex_mem = mem_busy;
        stall_mem_wb = mem_busy;
        stall_inc    = mem_busy;
      end
      default: ;
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign running   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign halted    = (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven RUN priority vectors plus
// directed start, drain, saturation and mid-drain reset sequences.
module tb_pipe_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, halt_req;
  logic [RA_W-1:0]  id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, mem_busy;
  logic             pipe_en, pc_we, running, halted;
  logic             stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic             flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.RA_W(RA_W), .DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .pipe_en(pipe_en), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pc_we(pc_we),
    .running(running), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex, pc_we}
  localparam logic [6:0] C_NORM   = 7'b0000001;
  localparam logic [6:0] C_LDUSE  = 7'b1000010;
  localparam logic [6:0] C_BRANCH = 7'b0000111;
  localparam logic [6:0] C_FREEZE = 7'b1111000;
  localparam logic [6:0] C_KILL   = 7'b0000110;
  localparam logic [6:0] C_DRBUSY = 7'b0011110;
  localparam logic [6:0] C_OFF    = 7'b0000000;

  typedef struct {
    logic            halt;
    logic [RA_W-1:0] rs1, rs2;
    logic            u1, u2, ld;
    logic [RA_W-1:0] rd;
    logic            br, busy;
    logic [6:0]      exp_ctl;
    int              sinc, finc;
  } vec_t;

  vec_t vecs[12];
  int   exp_stall, exp_flush;

  function automatic logic [6:0] ctl();
    return {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            flush_if_id, flush_id_ex, pc_we};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; halt_req = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_is_load = 0; ex_rd = 0; ex_br_taken = 0; mem_busy = 0;
  endtask

  task automatic do_reset_and_start();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    start = 1;
    tick();
    start = 0;
    #1;
  endtask

  initial begin
    vecs[0]  = '{0, 0,  0,  0, 0, 0, 0,  0, 0, C_NORM,   0, 0};
    vecs[1]  = '{0, 0,  7,  0, 1, 1, 7,  0, 0, C_LDUSE,  1, 0};
    vecs[2]  = '{0, 0,  7,  0, 1, 0, 7,  0, 0, C_NORM,   0, 0};
    vecs[3]  = '{0, 3,  0,  1, 0, 1, 3,  0, 0, C_LDUSE,  1, 0};
    vecs[4]  = '{0, 0,  0,  1, 1, 1, 0,  0, 0, C_NORM,   0, 0};
    vecs[5]  = '{0, 5,  9,  0, 1, 1, 5,  0, 0, C_NORM,   0, 0};
    vecs[6]  = '{0, 0,  7,  0, 1, 1, 7,  1, 0, C_BRANCH, 0, 1};
    vecs[7]  = '{0, 0,  7,  0, 1, 1, 7,  1, 1, C_FREEZE, 1, 0};
    vecs[8]  = '{0, 0,  0,  0, 0, 0, 0,  1, 0, C_BRANCH, 0, 1};
    vecs[9]  = '{1, 0,  0,  0, 0, 0, 0,  1, 1, C_FREEZE, 1, 0};
    vecs[10] = '{0, 12, 12, 1, 1, 1, 12, 0, 0, C_LDUSE,  1, 0};
    vecs[11] = '{0, 0,  0,  0, 0, 0, 0,  0, 1, C_FREEZE, 1, 0};

    // Reset state and start pulse in the third cycle after release.
    idle_inputs();
    rst_n = 0;
    #12;
    check("reset_pipe_en", pipe_en, 0);
    check("reset_status", {running, halted}, 0);
    check("reset_ctl", ctl(), C_OFF);
    check("reset_cnts", {stall_cnt, flush_cnt}, 0);
    rst_n = 1;
    tick();
    check("idle_c1_pipe_en", pipe_en, 0);
    tick();
    start = 1;
    #1;
    check("idle_c3_pipe_en", pipe_en, 0);
    check("idle_c3_ctl", ctl(), C_OFF);
    tick();
    start = 0;
    #1;
    check("run_pipe_en", pipe_en, 1);
    check("run_pc_we", pc_we, 1);
    check("run_running", running, 1);
    check("run_cnts", {stall_cnt, flush_cnt}, 0);

    // RUN priority table.
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 12; i++) begin
      halt_req = vecs[i].halt; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_use_rs1 = vecs[i].u1; id_use_rs2 = vecs[i].u2; ex_is_load = vecs[i].ld;
      ex_rd = vecs[i].rd; ex_br_taken = vecs[i].br; mem_busy = vecs[i].busy;
      #1;
      check($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp_ctl);
      tick();
      idle_inputs();
      #1;
      exp_stall += vecs[i].sinc;
      exp_flush += vecs[i].finc;
      check($sformatf("vec%0d_stall_cnt", i), stall_cnt, exp_stall);
      check($sformatf("vec%0d_flush_cnt", i), flush_cnt, exp_flush);
      check($sformatf("vec%0d_running", i), {running, halted}, 2'b10);
    end
    check("after_table_ctl", ctl(), C_NORM);

    // Halt with the first DRAIN cycle seeing mem_busy for three cycles.
    halt_req = 1;
    #1;
    check("halt_run_ctl", ctl(), C_KILL);
    tick();
    halt_req = 0;
    for (int i = 0; i < 5; i++) begin
      mem_busy    = (i < 3);
      ex_br_taken = (i == 3);
      ex_is_load  = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
      #1;
      check($sformatf("drain%0d_ctl", i), ctl(), (i < 3) ? C_DRBUSY : C_KILL);
      check($sformatf("drain%0d_status", i), {pipe_en, running, halted}, 3'b110);
      tick();
    end
    idle_inputs();
    #1;
    check("halted_status", {pipe_en, running, halted}, 3'b001);
    check("halted_ctl", ctl(), C_OFF);
    check("drain_stall_cnt", stall_cnt, exp_stall + 3);
    check("drain_flush_cnt", flush_cnt, exp_flush);
    start = 1;
    tick();
    tick();
    start = 0;
    #1;
    check("halted_sticky", {pipe_en, running, halted}, 3'b001);

    // Counter saturation at 2^CNT_W-1.
    do_reset_and_start();
    check("sat_start_running", running, 1);
    mem_busy = 1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_busy_ctl", ctl(), C_FREEZE);
    mem_busy = 0;
    #1;
    check("sat_stall_cnt", stall_cnt, 15);
    tick();
    check("sat_hold_cnt", stall_cnt, 15);
    check("sat_flush_cnt", flush_cnt, 0);

    // Reset asserted in the middle of DRAIN.
    do_reset_and_start();
    halt_req = 1;
    tick();
    halt_req = 0;
    mem_busy = 1;
    tick();
    check("mid_drain_running", {running, halted}, 2'b10);
    check("mid_drain_stall_cnt", stall_cnt, 1);
    rst_n = 0;
    #1;
    check("abort_status", {pipe_en, running, halted}, 3'b000);
    check("abort_ctl", ctl(), C_OFF);
    check("abort_cnts", {stall_cnt, flush_cnt}, 0);
    mem_busy = 0;
    #1;
    rst_n = 1;
    start = 1;
    #1;
    check("restart_idle", pipe_en, 0);
    tick();
    start = 0;
    #1;
    check("restart_running", {pipe_en, running, pc_we}, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
